// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD/binary conversion paths
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   localparam int DIGIT_W = 4;
   localparam logic [15:0] SAT_DEFAULT = 16'd9999;
endpackage

// File: rtl/mul10_add.sv
// mul10_add: combinational acc*10 + digit using shift-add
module mul10_add
   import bcd_pkg::*;
(
   input  logic [15:0]        acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [15:0]        sum
);
   assign sum = (acc << 3) + (acc << 1) + 16'(digit);
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential four-digit BCD to binary converter with illegal-digit saturation
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter logic [15:0] SAT_VALUE = SAT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DIGIT_W-1:0] thousands,
   input  logic [DIGIT_W-1:0] hundreds,
   input  logic [DIGIT_W-1:0] tens,
   input  logic [DIGIT_W-1:0] ones,
   output logic [15:0]        y,
   output logic               busy,
   output logic               done,
   output logic               err
);
   state_t state, next;
   logic [3:0][DIGIT_W-1:0] digits;
   logic [15:0] acc, sum;
   logic [1:0] cnt;
   logic bad;
   mul10_add u_mul10_add (
      .acc  (acc),
      .digit(digits[2'd3 - cnt]),
      .sum  (sum)
   );
   always_comb begin
      next = (state == IDLE) ? (start ? CONV : IDLE) :
             (state == CONV) ? ((cnt == 2'd3) ? DONE : CONV) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         y      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         bad    <= 1'b0;
         digits <= '0;
      end else begin
         state <= next;
         case (state)
            IDLE: if (start) begin
               digits <= {thousands, hundreds, tens, ones};
               acc    <= '0;
               cnt    <= '0;
               bad    <= (thousands > 4'd9) | (hundreds > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
               busy   <= 1'b1;
            end
            CONV: begin
               acc <= sum;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  y    <= bad ? SAT_VALUE : sum;
                  done <= 1'b1;
                  err  <= bad;
               end
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary
module tb_bcd_to_binary;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
   logic [15:0] y;
   logic busy, done, err;
   int compared = 0;
   int mismatched = 0;

   bcd_to_binary dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .thousands(thousands),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .y        (y),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic set_digits(input logic [3:0] t, input logic [3:0] h, input logic [3:0] n, input logic [3:0] o);
      thousands = t;
      hundreds  = h;
      tens      = n;
      ones      = o;
   endtask

   task automatic convert(input string tag, input logic [3:0] t, input logic [3:0] h,
                          input logic [3:0] n, input logic [3:0] o,
                          input logic [15:0] ey, input logic ee);
      int lat;
      set_digits(t, h, n, o);
      start = 1'b1;
      tick();
      start = 1'b0;
      set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      check({tag, "_busy"}, busy, 1);
      lat = 0;
      while (!done && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_y"}, y, ey);
      check({tag, "_err"}, err, ee);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_clr"}, busy, 0);
   endtask

   initial begin
      tick();
      tick();
      check("rst_y", y, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      start = 1'b1;
      tick();
      check("rst_prio_busy", busy, 0);
      start = 1'b0;
      rst_n = 1'b1;
      convert("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 16'd1234, 1'b0);
      convert("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 16'd9999, 1'b0);
      convert("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0);
      convert("c50a3", 4'd5, 4'd0, 4'hA, 4'd3, 16'd9999, 1'b1);
      tick();
      tick();
      check("err_hold", err, 1);
      convert("cffff", 4'hF, 4'hF, 4'hF, 4'hF, 16'd9999, 1'b1);
      convert("c0907", 4'd0, 4'd9, 4'd0, 4'd7, 16'd907, 1'b0);
      // start pulsed throughout edges 1..5 of a 0042 conversion must be ignored
      set_digits(4'd0, 4'd0, 4'd4, 4'd2);
      start = 1'b1;
      tick();
      set_digits(4'd9, 4'd9, 4'd9, 4'd9);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("busy_ign_done", done, (i == 4));
         if (i == 4) check("busy_ign_y", y, 42);
      end
      start = 1'b0;
      tick();
      check("busy_ign_idle", busy, 0);
      check("busy_ign_y_hold", y, 42);
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      start = 1'b1;
      tick();
      set_digits(4'd5, 4'd6, 4'd7, 4'd8);
      for (int i = 1; i <= 11; i++) begin
         tick();
         check("b2b_done", done, (i == 4 || i == 10));
         if (i == 4) check("b2b_y1", y, 1234);
         if (i == 10) check("b2b_y2", y, 5678);
      end
      start = 1'b0;
      tick();
      check("b2b_stop", busy, 0);
      set_digits(4'd7, 4'd7, 4'd7, 4'd7);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_done", done, 0);
      end
      check("abort_y", y, 0);
      check("abort_busy", busy, 0);
      check("abort_err", err, 0);
      convert("c0100", 4'd0, 4'd1, 4'd0, 4'd0, 16'd100, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
